// File: rtl/keypad_pkg.sv
// Shared keypad definitions: FSM states, matrix geometry and key-code mapping.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        HOLD    = 2'd2
    } kp_state_e;

    localparam int KEY_ROWS   = 4;
    localparam int KEY_COLS   = 3;
    localparam int KEY_CODE_W = 4;

    // Telephone-style layout: codes 0..8 are digits 1..9, bottom row is * 0 #.
    localparam logic [KEY_CODE_W-1:0] KEY_CODE_STAR = 4'd9;
    localparam logic [KEY_CODE_W-1:0] KEY_CODE_ZERO = 4'd10;
    localparam logic [KEY_CODE_W-1:0] KEY_CODE_HASH = 4'd11;

    // Linear key code from matrix position.
    function automatic logic [KEY_CODE_W-1:0] key_code_of(input int row, input int col,
                                                          input int cols);
        return KEY_CODE_W'(row * cols + col);
    endfunction

endpackage

// File: rtl/keypad_row_driver_if.sv
// Pin-side keypad bundle: column inputs in, row strobes and key events out.
interface keypad_row_driver_if
    import keypad_pkg::*;
#(
    parameter int ROWS = KEY_ROWS,
    parameter int COLS = KEY_COLS
);
    logic [COLS-1:0]       col_in;
    logic [ROWS-1:0]       row_out;
    logic [KEY_CODE_W-1:0] key_code;
    logic                  key_valid;
    logic                  key_held;

    // The row driver itself.
    modport master (
        input  col_in,
        output row_out,
        output key_code,
        output key_valid,
        output key_held
    );

    // Keypad pins / key-entry side.
    modport slave (
        output col_in,
        input  row_out,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the raw column lines plus one-hot check and column encode.
module keypad_col_sync #(
    parameter int COLS  = 3,
    parameter int COL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [COLS-1:0]  i_col,
    output logic [COLS-1:0]  o_col_s,
    output logic             o_onehot,
    output logic [COL_W-1:0] o_col_idx
);
    logic [COLS-1:0] r_sync1;
    logic [COLS-1:0] r_sync2;

    // Bring the asynchronous column lines into the clk domain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_col;
            r_sync2 <= r_sync1;
        end
    end

    // Exactly one bit set, and the position of the set bit.
    always_comb begin
        o_col_s   = r_sync2;
        o_onehot  = (r_sync2 != '0) && ((r_sync2 & (r_sync2 - 1'b1)) == '0);
        o_col_idx = '0;
        for (int i = 0; i < COLS; i++) begin
            if (r_sync2[i]) o_col_idx = COL_W'(i);
        end
    end
endmodule

// File: rtl/keypad_row_driver.sv
// Keypad matrix scanner: strobes rows, debounces one key at a time, emits key codes.
module keypad_row_driver
    import keypad_pkg::*;
#(
    parameter int ROWS     = KEY_ROWS,
    parameter int COLS     = KEY_COLS,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic                clk,
    input  logic                rst,
    keypad_row_driver_if.master kp
);
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DCNT_W = $clog2(SCAN_DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE + 1);

    logic [COLS-1:0]       w_col_s;
    logic                  w_onehot;
    logic [COL_W-1:0]      w_col_idx;
    logic                  w_sample;

    logic [DCNT_W-1:0]     r_dcnt;
    logic [ROW_W-1:0]      r_row;
    logic [COLS-1:0]       r_col_oh;
    logic [COL_W-1:0]      r_col_idx;
    logic [CNT_W-1:0]      r_match_cnt;
    logic [CNT_W-1:0]      r_rel_cnt;
    logic [KEY_CODE_W-1:0] r_key_code;
    logic                  r_key_valid;

    kp_state_e             r_state;
    kp_state_e             w_next_state;
    logic                  w_adv_row;
    logic                  w_latch;
    logic                  w_accept;

    keypad_col_sync #(
        .COLS  (COLS),
        .COL_W (COL_W)
    ) u_col_sync (
        .clk       (clk),
        .rst       (rst),
        .i_col     (kp.col_in),
        .o_col_s   (w_col_s),
        .o_onehot  (w_onehot),
        .o_col_idx (w_col_idx)
    );

    assign w_sample = (r_dcnt == DCNT_W'(SCAN_DIV - 1));

    // Free-running dwell counter; never realigned by the FSM so the scan grid stays fixed.
    always_ff @(posedge clk) begin
        if (!rst)          r_dcnt <= '0;
        else if (w_sample) r_dcnt <= '0;
        else               r_dcnt <= r_dcnt + 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= SCAN;
        else      r_state <= w_next_state;
    end

    // Next-state decisions, all taken only on the dwell-end sample cycle.
    always_comb begin
        w_next_state = r_state;
        w_adv_row    = 1'b0;
        w_latch      = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            SCAN: begin
                if (w_sample) begin
                    if (w_onehot) begin
                        w_next_state = CONFIRM;
                        w_latch      = 1'b1;
                    end else begin
                        w_adv_row = 1'b1;
                    end
                end
            end
            CONFIRM: begin
                if (w_sample) begin
                    if (w_col_s == r_col_oh) begin
                        if (r_match_cnt == CNT_W'(DEBOUNCE - 1)) begin
                            w_next_state = HOLD;
                            w_accept     = 1'b1;
                        end
                    end else begin
                        w_next_state = SCAN;
                        w_adv_row    = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (w_sample && (w_col_s == '0) && (r_rel_cnt == CNT_W'(DEBOUNCE - 1))) begin
                    w_next_state = SCAN;
                    w_adv_row    = 1'b1;
                end
            end
            default: w_next_state = SCAN;
        endcase
    end

    // Row pointer, latched key position, debounce counters and key event registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_row       <= '0;
            r_col_oh    <= '0;
            r_col_idx   <= '0;
            r_match_cnt <= '0;
            r_rel_cnt   <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
        end else begin
            r_key_valid <= w_accept;
            if (w_adv_row) begin
                r_row <= (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + 1'b1;
            end
            if (w_latch) begin
                r_col_oh    <= w_col_s;
                r_col_idx   <= w_col_idx;
                r_match_cnt <= '0;
            end else if (r_state == CONFIRM && w_sample && w_col_s == r_col_oh) begin
                r_match_cnt <= r_match_cnt + 1'b1;
            end
            if (w_accept) begin
                r_key_code <= key_code_of(int'(r_row), int'(r_col_idx), COLS);
                r_rel_cnt  <= '0;
            end else if (r_state == HOLD && w_sample) begin
                r_rel_cnt  <= (w_col_s == '0) ? r_rel_cnt + 1'b1 : '0;
            end
        end
    end

    // Outputs: one-hot row strobe and registered key event, held flag from state.
    always_comb begin
        kp.row_out        = '0;
        kp.row_out[r_row] = 1'b1;
        kp.key_code       = r_key_code;
        kp.key_valid      = r_key_valid;
        kp.key_held       = (r_state == HOLD);
    end
endmodule

// File: tb/tb_keypad_row_driver.sv
// Directed bench for keypad_row_driver with SCAN_DIV=4, DEBOUNCE=2.
module tb_keypad_row_driver;
    import keypad_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_pulse = 0;

    always #5 clk = ~clk;

    keypad_row_driver_if #(.ROWS(4), .COLS(3)) kif ();

    keypad_row_driver #(
        .ROWS     (4),
        .COLS     (3),
        .SCAN_DIV (4),
        .DEBOUNCE (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; sample outputs 1ns after the edge and tally key_valid pulses.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (kif.key_valid) n_pulse++;
        end
    endtask

    // Advance to the first cycle of a fresh dwell on the target row (dcnt == 0).
    task automatic wait_row_enter(input logic [3:0] target);
        int n;
        n = 0;
        while (kif.row_out == target && n < 64) begin tick(); n++; end
        while (kif.row_out != target && n < 64) begin tick(); n++; end
        check("row_wait_in_time", int'(n < 64), 1);
    endtask

    task automatic wait_held_low();
        int n;
        n = 0;
        while (kif.key_held && n < 64) begin tick(); n++; end
        check("held_wait_in_time", int'(n < 64), 1);
    endtask

    initial begin
        int p0;
        kif.col_in = '0;
        rst = 1'b0;
        tick(3);
        rst = 1'b1;
        n_pulse = 0;

        check("rst_row_out",   int'(kif.row_out),   1);
        check("rst_key_code",  int'(kif.key_code),  0);
        check("rst_key_valid", int'(kif.key_valid), 0);
        check("rst_key_held",  int'(kif.key_held),  0);

        // Idle scan: row advances every 4 cycles.
        for (int k = 1; k <= 40; k++) begin
            tick();
            check("idle_row_out", int'(kif.row_out), 1 << ((k / 4) % 4));
        end
        check("idle_no_pulse", n_pulse, 0);

        // Key 7: row 2, col 1.
        wait_row_enter(4'b0100);
        kif.col_in = 3'b010;
        tick(4);
        check("k7_row_frozen", int'(kif.row_out), 4);
        tick(7);
        check("k7_valid_early", int'(kif.key_valid), 0);
        tick();
        check("k7_valid",      int'(kif.key_valid), 1);
        check("k7_code",       int'(kif.key_code),  7);
        check("k7_held_rise",  int'(kif.key_held),  1);
        tick();
        check("k7_valid_pulse", int'(kif.key_valid), 0);
        tick(3);
        kif.col_in = 3'b000;
        tick(7);
        check("k7_held_before", int'(kif.key_held), 1);
        check("k7_one_pulse",   n_pulse, 1);
        tick();
        check("k7_held_fall",   int'(kif.key_held), 0);
        check("k7_row_adv",     int'(kif.row_out),  8);

        // One-sample bounce on row 0.
        p0 = n_pulse;
        wait_row_enter(4'b0001);
        kif.col_in = 3'b001;
        tick(4);
        kif.col_in = 3'b000;
        check("bounce_row_frozen", int'(kif.row_out), 1);
        tick(3);
        check("bounce_row_still",  int'(kif.row_out), 1);
        tick();
        check("bounce_row_adv",    int'(kif.row_out), 2);
        check("bounce_no_pulse",   n_pulse, p0);

        // Key 0 with a one-sample release gap, then a real release and re-press.
        wait_row_enter(4'b0001);
        kif.col_in = 3'b001;
        tick(12);
        check("k0_valid", int'(kif.key_valid), 1);
        check("k0_code",  int'(kif.key_code),  0);
        p0 = n_pulse;
        kif.col_in = 3'b000;
        tick(4);
        kif.col_in = 3'b001;
        tick(4);
        kif.col_in = 3'b000;
        check("k0_gap_held", int'(kif.key_held), 1);
        tick(7);
        check("k0_held_before", int'(kif.key_held), 1);
        tick();
        check("k0_held_fall",   int'(kif.key_held), 0);
        check("k0_gap_no_pulse", n_pulse, p0);
        wait_row_enter(4'b0001);
        kif.col_in = 3'b001;
        tick(12);
        check("k0_repress_valid", int'(kif.key_valid), 1);
        check("k0_repress_pulse", n_pulse, p0 + 1);
        kif.col_in = 3'b000;
        wait_held_low();

        // Multi-bit column in SCAN is ignored.
        p0 = n_pulse;
        kif.col_in = 3'b011;
        tick(20);
        check("multi_scan_no_pulse", n_pulse, p0);
        check("multi_scan_not_held", int'(kif.key_held), 0);
        kif.col_in = 3'b000;

        // Key 4 (row 1, col 1), then a second column joins during HOLD.
        wait_row_enter(4'b0010);
        kif.col_in = 3'b010;
        tick(12);
        check("k4_valid", int'(kif.key_valid), 1);
        check("k4_code",  int'(kif.key_code),  4);
        p0 = n_pulse;
        kif.col_in = 3'b011;
        tick(12);
        check("k4_multi_code",     int'(kif.key_code), 4);
        check("k4_multi_held",     int'(kif.key_held), 1);
        check("k4_multi_no_pulse", n_pulse, p0);
        kif.col_in = 3'b000;
        wait_held_low();

        // Reset in the middle of confirming key 11.
        p0 = n_pulse;
        wait_row_enter(4'b1000);
        kif.col_in = 3'b100;
        tick(4);
        check("k11_confirm_row", int'(kif.row_out), 8);
        tick(2);
        rst = 1'b0;
        tick();
        check("k11_rst_row_out",   int'(kif.row_out),   1);
        check("k11_rst_key_valid", int'(kif.key_valid), 0);
        check("k11_rst_key_code",  int'(kif.key_code),  0);
        check("k11_rst_key_held",  int'(kif.key_held),  0);
        rst = 1'b1;
        kif.col_in = 3'b000;
        tick(20);
        check("k11_no_pulse", n_pulse, p0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
